// File: rtl/stream_acc_pkg.sv
// stream_acc_pkg: shared state encoding and width helpers for the stream accumulator
package stream_acc_pkg;
  typedef enum logic [1:0] {IDLE, ACCUM, OUT} state_e;
  function automatic int acc_w(input int width, input int guard);
    return width + guard;
  endfunction
  function automatic int cnt_w(input int max_ops);
    return $clog2(max_ops + 1);
  endfunction
endpackage

// File: rtl/addsub_ovf.sv
// addsub_ovf: signed accumulator plus/minus unsigned operand with signed overflow detect
module addsub_ovf #(
  parameter int WIDTH = 8,
  parameter int ACC_W = 12
) (
  input  logic [ACC_W-1:0] acc,
  input  logic [WIDTH-1:0] op,
  input  logic             sub,
  output logic [ACC_W-1:0] res,
  output logic             ovf
);
  logic [ACC_W:0] acc_x, op_x, full;
  assign acc_x = {acc[ACC_W-1], acc};
  assign op_x  = (ACC_W+1)'(op);
  assign full  = sub ? acc_x - op_x : acc_x + op_x;
  assign res   = full[ACC_W-1:0];
  assign ovf   = full[ACC_W] ^ full[ACC_W-1];
endmodule

// File: rtl/stream_add_accumulator.sv
// stream_add_accumulator: packetised add/sub accumulator with sticky overflow, truncation and threshold compare
module stream_add_accumulator
  import stream_acc_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int GUARD = 4,
  parameter int MAX_OPS = 16,
  localparam int ACC_W = acc_w(WIDTH, GUARD),
  localparam int CNT_W = cnt_w(MAX_OPS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_sub,
  input  logic             in_last,
  input  logic [ACC_W-1:0] thresh,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic [CNT_W-1:0] out_count,
  output logic             out_ovf,
  output logic             out_trunc,
  output logic             out_le
);
  state_e state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d, res;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic ovf_q, ovf_d, trunc_q, trunc_d, step_ovf, accept, full;

  addsub_ovf #(.WIDTH(WIDTH), .ACC_W(ACC_W)) u_addsub (
    .acc(acc_q), .op(in_data), .sub(in_sub), .res(res), .ovf(step_ovf)
  );

  assign in_ready  = rst_n && (state_q == IDLE || state_q == ACCUM);
  assign accept    = in_valid && in_ready;
  assign cnt_inc   = cnt_q + CNT_W'(1);
  assign full      = cnt_inc == CNT_W'(MAX_OPS);
  assign out_valid = state_q == OUT;
  assign out_sum   = acc_q;
  assign out_count = cnt_q;
  assign out_ovf   = ovf_q;
  assign out_trunc = trunc_q;
  assign out_le    = $signed(acc_q) <= $signed(thresh);

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    trunc_d = trunc_q;
    case (state_q)
      IDLE, ACCUM: if (accept) begin
        acc_d   = res;
        cnt_d   = cnt_inc;
        ovf_d   = ovf_q | step_ovf;
        trunc_d = full && !in_last;
        state_d = (in_last || full) ? OUT : ACCUM;
      end
      OUT: if (out_ready) begin
        state_d = IDLE;
        acc_d   = '0;
        cnt_d   = '0;
        ovf_d   = 1'b0;
        trunc_d = 1'b0;
      end
      default: begin
        state_d = IDLE;
        acc_d   = '0;
        cnt_d   = '0;
        ovf_d   = 1'b0;
        trunc_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      trunc_q <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      trunc_q <= trunc_d;
    end
  end
endmodule
